// File: rtl/pu_riscv_verilog_pkg.sv
// Shared RISC-V constants for the execute-stage units.
//   RV32I / RV64I : encodings of the st_xlen mode field.
//   MUL..MULW     : {func7, func3, opcode[6:2]} match patterns of the
//                   multiply group.
//   mul_decode()  : maps {xlen32, pattern} onto a multiply operation.
package pu_riscv_verilog_pkg;

  localparam logic [1:0] RV32I = 2'b01;
  localparam logic [1:0] RV64I = 2'b10;

  localparam logic [14:0] MUL    = 15'b0000001_000_01100;
  localparam logic [14:0] MULH   = 15'b0000001_001_01100;
  localparam logic [14:0] MULHSU = 15'b0000001_010_01100;
  localparam logic [14:0] MULHU  = 15'b0000001_011_01100;
  localparam logic [14:0] MULW   = 15'b0000001_000_01110;

  typedef enum logic [1:0] {
    ST_CHK,
    ST_MUL,
    ST_RES
  } mul_state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_MUL,
    OP_MULH,
    OP_MULHSU,
    OP_MULHU,
    OP_MULW
  } mul_op_t;

  // MULW only exists when the hart is not running in 32-bit mode.
  function automatic mul_op_t mul_decode(input logic xlen32, input logic [14:0] key);
    mul_op_t op;
    op = OP_NONE;
    casez ({xlen32, key})
      {1'b?, MUL}    : op = OP_MUL;
      {1'b?, MULH}   : op = OP_MULH;
      {1'b?, MULHSU} : op = OP_MULHSU;
      {1'b?, MULHU}  : op = OP_MULHU;
      {1'b0, MULW}   : op = OP_MULW;
      default        : op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pu_riscv_mul.sv
// Bit-serial shift-add multiplier for MUL/MULH/MULHSU/MULHU/MULW.
// One partial-product bit per cycle; the pipeline is held via mul_stall
// while iterating and the result is presented for one cycle with
// mul_bubble low.
// Ports:
//   clk, rstn           : clock, asynchronous active-low reset
//   ex_stall            : execute stall, blocks acceptance of a new op
//   mul_stall           : high while an operation is iterating
//   id_bubble, id_instr : issued instruction and its validity
//   opA, opB            : rs1 / rs2 operands
//   st_xlen             : current XLEN mode (RV32I disables MULW)
//   mul_bubble, mul_r   : result strobe (active low) and result
module pu_riscv_mul
  import pu_riscv_verilog_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ILEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_stall,
  output logic            mul_stall,
  input  logic            id_bubble,
  input  logic [ILEN-1:0] id_instr,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [1:0]      st_xlen,
  output logic            mul_bubble,
  output logic [XLEN-1:0] mul_r
);

  localparam int CNTW = $clog2(XLEN);

  function automatic logic [XLEN-1:0] abs(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? (~x + XLEN'(1)) : x;
  endfunction

  function automatic logic [2*XLEN-1:0] twos(input logic [2*XLEN-1:0] x);
    return ~x + (2*XLEN)'(1);
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return XLEN'($signed(x));
  endfunction

  mul_state_t        r_state, w_state_next;
  logic [14:0]       r_mul_instr, w_mul_instr_next;
  logic [XLEN-1:0]   r_p, w_p_next;
  logic [XLEN-1:0]   r_a, w_a_next;
  logic [XLEN-1:0]   r_b, w_b_next;
  logic [CNTW-1:0]   r_cnt, w_cnt_next;
  logic              r_neg, w_neg_next;
  logic              r_mul_stall, w_mul_stall_next;
  logic              r_mul_bubble, w_mul_bubble_next;
  logic [XLEN-1:0]   r_mul_r, w_mul_r_next;

  logic [14:0]       w_id_key;
  mul_op_t           w_id_op;
  mul_op_t           w_res_op;
  logic              w_zero;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_prod;

  assign w_id_key = {id_instr[31:25], id_instr[14:12], id_instr[6:2]};
  assign w_id_op  = mul_decode(st_xlen == RV32I, w_id_key);
  // The captured instruction was already accepted, so MULW is legal here.
  assign w_res_op = mul_decode(1'b0, r_mul_instr);
  assign w_zero   = (w_id_op == OP_MULW) ? (opA[31:0] == '0 || opB[31:0] == '0)
                                         : (opA == '0 || opB == '0);
  assign w_sum    = {1'b0, r_p} + (r_a[0] ? {1'b0, r_b} : '0);
  assign w_prod   = r_neg ? twos({r_p, r_a}) : {r_p, r_a};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_CHK;
      r_mul_instr  <= '0;
      r_p          <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_neg        <= 1'b0;
      r_mul_stall  <= 1'b0;
      r_mul_bubble <= 1'b1;
      r_mul_r      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_mul_instr  <= w_mul_instr_next;
      r_p          <= w_p_next;
      r_a          <= w_a_next;
      r_b          <= w_b_next;
      r_cnt        <= w_cnt_next;
      r_neg        <= w_neg_next;
      r_mul_stall  <= w_mul_stall_next;
      r_mul_bubble <= w_mul_bubble_next;
      r_mul_r      <= w_mul_r_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_mul_instr_next  = r_mul_instr;
    w_p_next          = r_p;
    w_a_next          = r_a;
    w_b_next          = r_b;
    w_cnt_next        = r_cnt;
    w_neg_next        = r_neg;
    w_mul_stall_next  = r_mul_stall;
    w_mul_bubble_next = 1'b1;
    w_mul_r_next      = r_mul_r;

    unique case (r_state)
      ST_CHK: begin
        // Capture only while idle so traffic on id_instr during the
        // iteration cannot change the op that ST_RES finalizes.
        if (!ex_stall) w_mul_instr_next = w_id_key;
        if (!ex_stall && !id_bubble && w_id_op != OP_NONE) begin
          if (w_zero) begin
            w_mul_r_next      = '0;
            w_mul_bubble_next = 1'b0;
          end else begin
            w_mul_stall_next = 1'b1;
            w_state_next     = ST_MUL;
            w_p_next         = '0;
            w_cnt_next       = (w_id_op == OP_MULW) ? CNTW'(31) : CNTW'(XLEN-1);
            unique case (w_id_op)
              OP_MULH: begin
                w_a_next   = abs(opB);
                w_b_next   = abs(opA);
                w_neg_next = opA[XLEN-1] ^ opB[XLEN-1];
              end
              OP_MULHSU: begin
                w_a_next   = opB;
                w_b_next   = abs(opA);
                w_neg_next = opA[XLEN-1];
              end
              OP_MULW: begin
                w_a_next   = XLEN'(opB[31:0]);
                w_b_next   = XLEN'(opA[31:0]);
                w_neg_next = 1'b0;
              end
              default: begin
                // MUL (low half is sign-independent) and MULHU
                w_a_next   = opB;
                w_b_next   = opA;
                w_neg_next = 1'b0;
              end
            endcase
          end
        end
      end

      ST_MUL: begin
        // The multiplier drains out of the bottom of a while the
        // product bits fill {p, a} from the top.
        {w_p_next, w_a_next} = {w_sum, r_a[XLEN-1:1]};
        w_cnt_next = r_cnt - CNTW'(1);
        if (r_cnt == '0) w_state_next = ST_RES;
      end

      ST_RES: begin
        unique case (w_res_op)
          OP_MULH, OP_MULHSU, OP_MULHU: w_mul_r_next = w_prod[2*XLEN-1:XLEN];
          OP_MULW:                      w_mul_r_next = sext32(r_a[XLEN-1 -: 32]);
          default:                      w_mul_r_next = w_prod[XLEN-1:0];
        endcase
        w_mul_bubble_next = 1'b0;
        w_mul_stall_next  = 1'b0;
        w_state_next      = ST_CHK;
      end

      default: w_state_next = ST_CHK;
    endcase
  end

  assign mul_stall  = r_mul_stall;
  assign mul_bubble = r_mul_bubble;
  assign mul_r      = r_mul_r;

endmodule
